program_loader: RTL and testbench

//  Boot-time program loader: takes a byte stream (valid/ready), packs little-endian 32-bit words,

---
 rtl/loader_pkg.sv | 17 +
 rtl/byte_assembler.sv | 32 +++
 rtl/program_loader.sv | 146 ++++++++++++++
 tb/tb_program_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM state encodings and stream framing sizes.
package loader_pkg;

  localparam int HEADER_BYTES = 4;
  localparam int WORD_BYTES   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/byte_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word_valid marks the cycle the 4th byte arrives.
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [1:0]  byte_index,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [31:0] shreg;

  // NOTE: sequential state uses non-blocking assignments only; combinational paths stay in assigns/always_comb.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      byte_index <= '0;
      shreg      <= '0;
    end else if (shift_en) begin
      byte_index <= byte_index + 2'd1;
      shreg      <= {byte_in, shreg[31:8]};
    end
  end

  // The completed word is presented in the same cycle as its last byte.
  assign word       = {byte_in, shreg[31:8]};
  assign word_valid = shift_en && (byte_index == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/program_loader.sv
// Boot-time loader: header word count, then data words written to memory; releases cpu_reset when done.
// Optional LOADER_CHECKSUM_EN adds a trailing 32-bit checksum word verified before release.
module program_loader
  import loader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          MAX_WORDS  = 16384
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  localparam logic [1:0] LAST_HDR_IDX = 2'(HEADER_BYTES - 1);

  state_t      state, state_next;
  logic        transfer;
  logic        asm_clear;
  logic [1:0]  byte_index;
  logic [31:0] asm_word;
  logic        word_valid;
  logic        hdr_done;
  logic        last_word;
  logic [15:0] word_count;
  logic [31:0] addr_full;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum_acc;
`endif

  assign transfer  = in_valid && in_ready;
  assign hdr_done  = transfer && (byte_index == LAST_HDR_IDX);
  assign last_word = (words_loaded + 16'd1) == word_count;

  byte_assembler u_asm (
    .clock      (clock),
    .reset      (reset),
    .clear      (asm_clear),
    .shift_en   (transfer),
    .byte_in    (in_data),
    .byte_index (byte_index),
    .word       (asm_word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next   = state;
    in_ready     = 1'b0;
    mem_write_en = 1'b0;
    cpu_reset    = 1'b1;
    done         = 1'b0;
    error        = 1'b0;
    asm_clear    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_LEN;
          asm_clear  = 1'b1;
        end
      end
      ST_LEN: begin
        in_ready = 1'b1;
        if (hdr_done) begin
          if (asm_word == 32'd0 || asm_word > 32'(MAX_WORDS)) state_next = ST_ERROR;
          else                                                 state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        in_ready = 1'b1;
        if (word_valid) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        mem_write_en = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        state_next = last_word ? ST_CSUM : ST_DATA;
`else
        state_next = last_word ? ST_DONE : ST_DATA;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM: begin
        in_ready = 1'b1;
        if (word_valid) state_next = (asm_word == csum_acc) ? ST_DONE : ST_ERROR;
      end
`endif
      ST_DONE: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
      end
      ST_ERROR: begin
        error = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      words_loaded   <= '0;
      word_count     <= '0;
      mem_write_data <= '0;
    end else begin
      if (state == ST_IDLE && start) words_loaded <= '0;
      // Validated counts never exceed MAX_WORDS, so 16 bits hold any accepted value.
      if (state == ST_LEN && hdr_done) word_count <= asm_word[15:0];
      if (state == ST_DATA && word_valid) mem_write_data <= asm_word;
      if (state == ST_WRITE) words_loaded <= words_loaded + 16'd1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      csum_acc <= '0;
    end else if (state == ST_IDLE && start) begin
      csum_acc <= '0;
    end else if (state == ST_WRITE) begin
      csum_acc <= csum_acc + mem_write_data;
    end
  end
`endif

  // Address wraps silently at the top of the ADDR_WIDTH space.
  assign addr_full   = BASE_ADDR + 32'({words_loaded, 2'b00});
  assign mem_address = addr_full[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: two instances (base 0 and base 0xFFF8) share one byte stream.
module tb_program_loader;

  logic        clock = 1'b0;
  logic        reset, start, in_valid;
  logic [7:0]  in_data;

  logic        in_ready, mem_write_en, cpu_reset, done, error;
  logic [15:0] mem_address, words_loaded;
  logic [31:0] mem_write_data;

  logic        hi_in_ready, hi_mem_write_en, hi_cpu_reset, hi_done, hi_error;
  logic [15:0] hi_mem_address, hi_words_loaded;
  logic [31:0] hi_mem_write_data;

  program_loader #(.ADDR_WIDTH(16), .BASE_ADDR(32'h0), .MAX_WORDS(16384)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_write_en(mem_write_en), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .cpu_reset(cpu_reset), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  program_loader #(.ADDR_WIDTH(16), .BASE_ADDR(32'hFFF8), .MAX_WORDS(16384)) dut_hi (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(hi_in_ready), .mem_write_en(hi_mem_write_en), .mem_address(hi_mem_address),
    .mem_write_data(hi_mem_write_data), .cpu_reset(hi_cpu_reset), .done(hi_done), .error(hi_error),
    .words_loaded(hi_words_loaded)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] addr_hi;
    logic [31:0] data;
    logic        ready;
  } wr_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic [31:0] addr_hi;
  } vec_t;

  wr_t         wr_q[$];
  logic [31:0] words[$];
  vec_t        vec[3];
  logic [31:0] bad_hdr[2];
  int          passed = 0;
  int          total  = 0;
  bit          stall  = 1'b0;

  always @(negedge clock) begin
    if (mem_write_en)
      wr_q.push_back('{addr: 32'(mem_address), addr_hi: 32'(hi_mem_address),
                       data: mem_write_data, ready: in_ready});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    tick; tick;
    reset = 1'b0;
    wr_q.delete();
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      tick;
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
    if (stall) tick;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_load(input logic [31:0] n, input logic [31:0] csum_adj);
    logic [31:0] sum;
    sum = 32'd0;
    pulse_start;
    send_word(n);
    foreach (words[i]) begin
      send_word(words[i]);
      sum += words[i];
    end
`ifdef LOADER_CHECKSUM_EN
    if (words.size() > 0) send_word(sum + csum_adj);
`else
    if (csum_adj != 32'd0) sum = 32'd0;
`endif
  endtask

  task automatic wait_end;
    int n;
    n = 0;
    while (!done && !error && n < 100) begin
      tick;
      n++;
    end
    if (n >= 100) check("end_timeout", 32'(done | error), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"},     32'(in_ready),       32'd0);
    check({tag, "_write_en"},     32'(mem_write_en),   32'd0);
    check({tag, "_address"},      32'(mem_address),    32'h0000);
    check({tag, "_address_hi"},   32'(hi_mem_address), 32'hFFF8);
    check({tag, "_write_data"},   mem_write_data,      32'd0);
    check({tag, "_cpu_reset"},    32'(cpu_reset),      32'd1);
    check({tag, "_done"},         32'(done),           32'd0);
    check({tag, "_error"},        32'(error),          32'd0);
    check({tag, "_words_loaded"}, 32'(words_loaded),   32'd0);
  endtask

  initial begin
    vec[0] = '{data: 32'h0000_0013, addr: 32'h0, addr_hi: 32'hFFF8};
    vec[1] = '{data: 32'h00A0_0093, addr: 32'h4, addr_hi: 32'hFFFC};
    vec[2] = '{data: 32'h0000_8067, addr: 32'h8, addr_hi: 32'h0000};
    bad_hdr[0] = 32'd0;
    bad_hdr[1] = 32'd16385;

    // Reset state
    do_reset;
    check_reset_state("rst");

    // Three-word program, both base addresses including the 16-bit wrap
    words.delete();
    foreach (vec[i]) words.push_back(vec[i].data);
    send_load(32'd3, 32'd0);
    wait_end;
    check("t1_done",         32'(done),            32'd1);
    check("t1_cpu_reset",    32'(cpu_reset),       32'd0);
    check("t1_error",        32'(error),           32'd0);
    check("t1_words_loaded", 32'(words_loaded),    32'd3);
    check("t1_hi_words",     32'(hi_words_loaded), 32'd3);
    check("t1_write_count",  32'(wr_q.size()),     32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < wr_q.size()) begin
        check($sformatf("t1_addr%0d", i),    wr_q[i].addr,          vec[i].addr);
        check($sformatf("t1_addr_hi%0d", i), wr_q[i].addr_hi,       vec[i].addr_hi);
        check($sformatf("t1_data%0d", i),    wr_q[i].data,          vec[i].data);
        check($sformatf("t1_ready%0d", i),   32'(wr_q[i].ready),    32'd0);
      end
    end
    pulse_start;
    check("t1_start_ignored", 32'(done), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    tick;
    check("t1_done_not_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    // Rejected headers: zero and one above MAX_WORDS
    for (int h = 0; h < 2; h++) begin
      do_reset;
      words.delete();
      send_load(bad_hdr[h], 32'd0);
      wait_end;
      check($sformatf("t2_error_%0d", h),     32'(error),       32'd1);
      check($sformatf("t2_cpu_reset_%0d", h), 32'(cpu_reset),   32'd1);
      check($sformatf("t2_done_%0d", h),      32'(done),        32'd0);
      check($sformatf("t2_in_ready_%0d", h),  32'(in_ready),    32'd0);
      tick; tick;
      check($sformatf("t2_no_write_%0d", h),  32'(wr_q.size()), 32'd0);
    end

    // Stalled stream: in_valid low every other cycle
    do_reset;
    words.delete();
    words.push_back(32'hDEAD_BEEF);
    words.push_back(32'h1234_5678);
    stall = 1'b1;
    send_load(32'd2, 32'd0);
    stall = 1'b0;
    wait_end;
    check("t3_done",        32'(done),        32'd1);
    check("t3_write_count", 32'(wr_q.size()), 32'd2);
    for (int i = 0; i < 2; i++) begin
      if (i < wr_q.size()) begin
        check($sformatf("t3_addr%0d", i),  wr_q[i].addr,       32'(4 * i));
        check($sformatf("t3_data%0d", i),  wr_q[i].data,       words[i]);
        check($sformatf("t3_ready%0d", i), 32'(wr_q[i].ready), 32'd0);
      end
    end

    // Reset after 5 data bytes of N=4, then a fresh load
    do_reset;
    pulse_start;
    send_word(32'd4);
    send_word(32'hA5A5_0001);
    send_byte(8'h77);
    check("t4_partial_words", 32'(words_loaded), 32'd1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check_reset_state("t4");
    wr_q.delete();
    words.delete();
    words.push_back(32'hCAFE_F00D);
    send_load(32'd1, 32'd0);
    wait_end;
    check("t4_done",        32'(done),        32'd1);
    check("t4_write_count", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() > 0) begin
      check("t4_addr", wr_q[0].addr, 32'h0);
      check("t4_data", wr_q[0].data, 32'hCAFE_F00D);
    end

`ifdef LOADER_CHECKSUM_EN
    // Checksum: 1 + 2 == 3 accepted, 4 rejected with both words written
    do_reset;
    words.delete();
    words.push_back(32'd1);
    words.push_back(32'd2);
    send_load(32'd2, 32'd0);
    wait_end;
    check("t6_good_done",  32'(done),  32'd1);
    check("t6_good_error", 32'(error), 32'd0);
    do_reset;
    send_load(32'd2, 32'd1);
    wait_end;
    check("t6_bad_error",     32'(error),       32'd1);
    check("t6_bad_done",      32'(done),        32'd0);
    check("t6_bad_cpu_reset", 32'(cpu_reset),   32'd1);
    check("t6_bad_writes",    32'(wr_q.size()), 32'd2);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
